mole_judge: RTL and testbench

Upstream game-play stage of the whack-a-mole core. Picks a pseudo-random hole each round, raises the mole there for a bounded number of one-second ticks, and judges player key presses against it. Emits the one-cycle `player_signal` hit pulse and the `timer_signal` game-over level consumed by the score/memory datapath. Also keeps round and hit counts for display.

---
 rtl/mole_judge.sv | 185 ++++++++++++++++++
 tb/tb_mole_judge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mole_judge.sv
// Whack-a-mole game-play judge: picks holes, raises moles, scores key presses.
// Optional MOLE_WRONG_KEY_MISS_EN: a wrong-key press in UP pulses miss.
module mole_judge #(
    parameter int         HOLES      = 4,
    parameter int         WINDOW     = 3,
    parameter int         GAME_TICKS = 30,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic             start,
    input  logic [HOLES-1:0] keys,
    output logic [HOLES-1:0] mole_onehot,
    output logic             player_signal,
    output logic             miss,
    output logic             timer_signal,
    output logic [7:0]       round_count,
    output logic [7:0]       hit_count
);
    // state | meaning
    // IDLE  | waiting for start, counters cleared
    // PICK  | step LFSR, choose next hole (one cycle)
    // UP    | mole raised, judging key edges against the window
    // DOWN  | mole lowered, waiting for the next tick
    // DONE  | game time expired, timer_signal held until start drops
    typedef enum logic [2:0] {S_IDLE, S_PICK, S_UP, S_DOWN, S_DONE} state_t;

    localparam int HW = $clog2(HOLES);

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [HW-1:0]    hole_q, hole_d;
    logic             prev_vld_q, prev_vld_d;
    logic [HOLES-1:0] keys_q;
    logic [3:0]       win_q, win_d;
    logic [7:0]       game_q, game_d;
    logic [HOLES-1:0] mole_q, mole_d;
    logic             player_q, player_d;
    logic             miss_q, miss_d;
    logic             timer_q, timer_d;
    logic [7:0]       round_q, round_d;
    logic [7:0]       hit_q, hit_d;

    logic [HOLES-1:0] key_edge;
    logic [HOLES-1:0] mole_mask;
    logic             hit_edge;
    logic             wrong_edge;
    logic [7:0]       lfsr_step;
    logic [HW-1:0]    pick_raw;
    logic [HW-1:0]    pick_hole;
    logic             active;
    logic             game_end;

    // XNOR feedback on taps 8,6,5,4; the all-ones state is the lock-up value.
    assign lfsr_step  = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3])};
    assign pick_raw   = lfsr_step[HW-1:0];
    assign pick_hole  = (prev_vld_q && (pick_raw == hole_q)) ? pick_raw + HW'(1) : pick_raw;
    assign key_edge   = keys & ~keys_q;
    assign mole_mask  = HOLES'(1) << hole_q;
    assign hit_edge   = key_edge[hole_q];
    assign wrong_edge = |(key_edge & ~mole_mask);
    assign active     = (state_q == S_PICK) || (state_q == S_UP) || (state_q == S_DOWN);
    assign game_end   = tick && (game_q == 8'd1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        hole_d     = hole_q;
        prev_vld_d = prev_vld_q;
        win_d      = win_q;
        game_d     = game_q;
        player_d   = 1'b0;
        miss_d     = 1'b0;
        round_d    = round_q;
        hit_d      = hit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    game_d  = 8'(GAME_TICKS);
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                lfsr_d     = lfsr_step;
                hole_d     = pick_hole;
                prev_vld_d = 1'b1;
                win_d      = 4'(WINDOW);
                round_d    = sat_inc(round_q);
                state_d    = S_UP;
            end
            S_UP: begin
                if (tick) win_d = win_q - 4'd1;
                if (hit_edge) begin
                    player_d = 1'b1;
                    hit_d    = sat_inc(hit_q);
                    state_d  = S_DOWN;
                end else if (tick && (win_q == 4'd1)) begin
                    miss_d  = 1'b1;
                    state_d = S_DOWN;
                end
`ifdef MOLE_WRONG_KEY_MISS_EN
                else if (wrong_edge) begin
                    miss_d = 1'b1;
                end
`endif
            end
            S_DOWN: begin
                if (tick) state_d = S_PICK;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Game expiry overrides window/DOWN moves; a same-cycle hit still counts.
        if (active) begin
            if (tick) game_d = game_q - 8'd1;
            if (game_end) begin
                state_d = S_DONE;
                miss_d  = 1'b0;
                round_d = round_q;
            end
            if (!start) begin
                state_d  = S_IDLE;
                player_d = 1'b0;
                miss_d   = 1'b0;
            end
        end

        if (state_d == S_IDLE) begin
            round_d    = 8'd0;
            hit_d      = 8'd0;
            prev_vld_d = 1'b0;
        end
    end

    assign mole_d  = (state_d == S_UP) ? (HOLES'(1) << hole_d) : '0;
    assign timer_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            hole_q     <= '0;
            prev_vld_q <= 1'b0;
            keys_q     <= '0;
            win_q      <= '0;
            game_q     <= '0;
            mole_q     <= '0;
            player_q   <= 1'b0;
            miss_q     <= 1'b0;
            timer_q    <= 1'b0;
            round_q    <= '0;
            hit_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            hole_q     <= hole_d;
            prev_vld_q <= prev_vld_d;
            keys_q     <= keys;
            win_q      <= win_d;
            game_q     <= game_d;
            mole_q     <= mole_d;
            player_q   <= player_d;
            miss_q     <= miss_d;
            timer_q    <= timer_d;
            round_q    <= round_d;
            hit_q      <= hit_d;
        end
    end

    assign mole_onehot   = mole_q;
    assign player_signal = player_q;
    assign miss          = miss_q;
    assign timer_signal  = timer_q;
    assign round_count   = round_q;
    assign hit_count     = hit_q;
endmodule

// File: tb/tb_mole_judge.sv
// Directed bench for mole_judge: default game instance plus a 5-tick game instance.
module tb_mole_judge;
    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] keys = 4'b0000;

    logic [3:0] m_mole;
    logic       m_player, m_miss, m_timer;
    logic [7:0] m_round, m_hit;
    logic [3:0] f_mole;
    logic       f_player, f_miss, f_timer;
    logic [7:0] f_round, f_hit;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mole_judge dut (
        .clk(clk), .Reset(Reset), .tick(tick), .start(start), .keys(keys),
        .mole_onehot(m_mole), .player_signal(m_player), .miss(m_miss),
        .timer_signal(m_timer), .round_count(m_round), .hit_count(m_hit)
    );

    mole_judge #(.GAME_TICKS(5)) dut5 (
        .clk(clk), .Reset(Reset), .tick(tick), .start(start), .keys(keys),
        .mole_onehot(f_mole), .player_signal(f_player), .miss(f_miss),
        .timer_signal(f_timer), .round_count(f_round), .hit_count(f_hit)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; start = 1'b0; keys = 4'b0000; tick = 1'b0;
        step(); step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({m_mole, m_player, m_miss, m_timer} !== 7'd0) $display("FAIL reset_outs got=%b exp=0", {m_mole, m_player, m_miss, m_timer}); else passed++;
        total++; if ({m_round, m_hit} !== 16'd0) $display("FAIL reset_counts got=%h exp=0", {m_round, m_hit}); else passed++;
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        total++; if (m_mole !== 4'b0000) $display("FAIL pick_mole got=%b exp=0000", m_mole); else passed++;
        step();
        total++; if (m_mole !== 4'b1000) $display("FAIL first_mole got=%b exp=1000", m_mole); else passed++;
        total++; if (m_round !== 8'd1) $display("FAIL first_round got=%0d exp=1", m_round); else passed++;
    endtask

    task automatic test_wrong_key();
        logic exp_miss;
`ifdef MOLE_WRONG_KEY_MISS_EN
        exp_miss = 1'b1;
`else
        exp_miss = 1'b0;
`endif
        keys = 4'b0001;
        step();
        total++; if (m_miss !== exp_miss) $display("FAIL wrong_key_miss got=%b exp=%b", m_miss, exp_miss); else passed++;
        total++; if (m_player !== 1'b0) $display("FAIL wrong_key_player got=%b exp=0", m_player); else passed++;
        step();
        total++; if (m_miss !== 1'b0) $display("FAIL wrong_key_once got=%b exp=0", m_miss); else passed++;
        total++; if (m_mole !== 4'b1000) $display("FAIL wrong_key_mole got=%b exp=1000", m_mole); else passed++;
        keys = 4'b0000;
        step();
    endtask

    task automatic test_hit();
        keys = 4'b1000;
        step();
        total++; if (m_player !== 1'b1) $display("FAIL hit_pulse got=%b exp=1", m_player); else passed++;
        total++; if (m_hit !== 8'd1) $display("FAIL hit_count got=%0d exp=1", m_hit); else passed++;
        total++; if (m_mole !== 4'b0000) $display("FAIL hit_mole_off got=%b exp=0000", m_mole); else passed++;
        step();
        total++; if (m_player !== 1'b0) $display("FAIL hit_one_cycle got=%b exp=0", m_player); else passed++;
        keys = 4'b0000;
        step();
    endtask

    task automatic test_window_miss();
        tick_pulse();
        step();
        total++; if (m_mole !== 4'b0100) $display("FAIL second_mole got=%b exp=0100", m_mole); else passed++;
        total++; if (m_round !== 8'd2) $display("FAIL second_round got=%0d exp=2", m_round); else passed++;
        tick_pulse(); step();
        tick_pulse(); step();
        total++; if ({m_miss, m_mole} !== 5'b0_0100) $display("FAIL window_early got=%b exp=00100", {m_miss, m_mole}); else passed++;
        tick_pulse();
        total++; if ({m_miss, m_mole} !== 5'b1_0000) $display("FAIL window_miss got=%b exp=10000", {m_miss, m_mole}); else passed++;
        step();
        total++; if (m_miss !== 1'b0) $display("FAIL window_miss_once got=%b exp=0", m_miss); else passed++;
        total++; if (m_mole !== 4'b0000) $display("FAIL down_wait got=%b exp=0000", m_mole); else passed++;
        tick_pulse();
        step();
        total++; if (m_mole !== 4'b0010) $display("FAIL third_mole got=%b exp=0010", m_mole); else passed++;
    endtask

    task automatic test_collision();
        keys = 4'b0010;
        step();
        total++; if (m_hit !== 8'd2) $display("FAIL hit2_count got=%0d exp=2", m_hit); else passed++;
        tick_pulse();
        step();
        total++; if (m_mole !== 4'b1000) $display("FAIL fourth_mole got=%b exp=1000", m_mole); else passed++;
        keys = 4'b1000;
        step();
        keys = 4'b0000;
        tick_pulse();
        step();
        total++; if (m_mole !== 4'b0001) $display("FAIL collision_mole got=%b exp=0001", m_mole); else passed++;
        total++; if ({m_round, m_hit} !== {8'd5, 8'd3}) $display("FAIL collision_counts got=%h exp=0503", {m_round, m_hit}); else passed++;
    endtask

    task automatic test_held_key();
        keys = 4'b0001;
        step();
        keys = 4'b0100;
        step();
        total++; if (m_player !== 1'b0) $display("FAIL down_edge_ignored got=%b exp=0", m_player); else passed++;
        tick_pulse();
        step();
        total++; if (m_mole !== 4'b0100) $display("FAIL sixth_mole got=%b exp=0100", m_mole); else passed++;
        step(); step();
        total++; if ({m_player, m_hit} !== {1'b0, 8'd4}) $display("FAIL held_no_hit got=%b/%0d exp=0/4", m_player, m_hit); else passed++;
    endtask

    task automatic test_abort();
        start = 1'b0;
        keys = 4'b0000;
        step();
        total++; if ({m_mole, m_player, m_miss, m_timer, m_round, m_hit} !== 23'd0) $display("FAIL abort_idle got=%h exp=0", {m_mole, m_player, m_miss, m_timer, m_round, m_hit}); else passed++;
    endtask

    task automatic test_game_timer();
        do_reset();
        start = 1'b1;
        step(); step();
        total++; if (f_mole !== 4'b1000) $display("FAIL g5_first_mole got=%b exp=1000", f_mole); else passed++;
        tick_pulse(); step();
        tick_pulse(); step();
        tick_pulse(); step();
        tick_pulse(); step();
        total++; if ({f_timer, f_mole} !== 5'b0_0100) $display("FAIL g5_before_end got=%b exp=00100", {f_timer, f_mole}); else passed++;
        tick_pulse();
        total++; if ({f_timer, f_mole} !== 5'b1_0000) $display("FAIL g5_timer_rise got=%b exp=10000", {f_timer, f_mole}); else passed++;
        step(); step(); tick_pulse(); step();
        total++; if ({f_timer, f_round} !== {1'b1, 8'd2}) $display("FAIL g5_done_hold got=%b/%0d exp=1/2", f_timer, f_round); else passed++;
        start = 1'b0;
        step();
        total++; if ({f_mole, f_player, f_miss, f_timer, f_round, f_hit} !== 23'd0) $display("FAIL g5_back_idle got=%h exp=0", {f_mole, f_player, f_miss, f_timer, f_round, f_hit}); else passed++;
    endtask

    task automatic test_final_tick_hit();
        do_reset();
        start = 1'b1;
        step(); step();
        tick_pulse(); step();
        tick_pulse(); step();
        keys = 4'b1000;
        step();
        total++; if (f_hit !== 8'd1) $display("FAIL fth_first_hit got=%0d exp=1", f_hit); else passed++;
        keys = 4'b0000;
        tick_pulse();
        step();
        total++; if (f_mole !== 4'b0100) $display("FAIL fth_mole got=%b exp=0100", f_mole); else passed++;
        tick_pulse(); step();
        keys = 4'b0100;
        tick_pulse();
        total++; if ({f_player, f_timer, f_mole} !== 6'b11_0000) $display("FAIL fth_end got=%b exp=110000", {f_player, f_timer, f_mole}); else passed++;
        total++; if (f_hit !== 8'd2) $display("FAIL fth_hit_count got=%0d exp=2", f_hit); else passed++;
        step();
        total++; if ({f_player, f_timer} !== 2'b01) $display("FAIL fth_after got=%b exp=01", {f_player, f_timer}); else passed++;
        start = 1'b0;
        keys = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrong_key();
        test_hit();
        test_window_miss();
        test_collision();
        test_held_key();
        test_abort();
        test_game_timer();
        test_final_tick_hit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
